ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter, the send side of the keyboard link. It takes one command byte over a valid/ready handshake and runs the PS/2 host-request sequence: inhibit, start, 8 data bits LSB first, odd parity, stop, then checks the device ACK. It drives the open-collector PS2_CLK/PS2_DAT pads through output-enable signals alongside the existing keyboard receiver. Typical bytes are keyboard LED commands (0xED) and enable (0xF4).

---
 rtl/ps2_pkg.sv | 40 ++++
 rtl/ps2_line_filter.sv | 48 ++++
 rtl/ps2_host_tx.sv | 177 +++++++++++++++++
 tb/tb_ps2_host_tx.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: controller states, odd parity and default timing.
// Timing defaults are expressed in microseconds and scaled by the system clock.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        WAIT_EDGE,
        WAIT_IDLE,
        DONE,
        ERR
    } ps2_state_e;

    localparam int DEF_CLK_FREQ_HZ  = 50_000_000;
    localparam int INHIBIT_US       = 120;
    localparam int START_TIMEOUT_US = 15_000;
    localparam int XFER_TIMEOUT_US  = 2_000;
    localparam int DEF_FILTER_LEN   = 8;

    function automatic int cycles_for_us(input int clk_hz, input int us);
        return (clk_hz / 1_000_000) * us;
    endfunction

    localparam int DEF_INHIBIT_CYCLES = cycles_for_us(DEF_CLK_FREQ_HZ, INHIBIT_US);
    localparam int DEF_START_TIMEOUT  = cycles_for_us(DEF_CLK_FREQ_HZ, START_TIMEOUT_US);
    localparam int DEF_XFER_TIMEOUT   = cycles_for_us(DEF_CLK_FREQ_HZ, XFER_TIMEOUT_US);

    // Odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Pad conditioner: 2-FF synchronizer then a FILTER_LEN-sample agreement filter, idle-high.
// Latency: 2 sync cycles + FILTER_LEN samples before filt_out follows a pad change.
// Backpressure: none; free-running every clock.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic pad_in,
    output logic filt_out
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic          sync1_q, sync2_q;
    logic          filt_q, filt_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            filt_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= pad_in;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    // Any sample that agrees with the current output restarts the run count.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync2_q != filt_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1)) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign filt_out = filt_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, start, 8 data LSB first, odd parity, stop, ACK check.
// Latency: INHIBIT_CYCLES then device-clocked; outputs registered, oe updates 1 cycle after edge detect.
// Backpressure: tx_ready only in IDLE; tx_valid ignored while busy.
module ps2_host_tx import ps2_pkg::*; #(
    parameter int CLK_FREQ_HZ    = DEF_CLK_FREQ_HZ,
    parameter int INHIBIT_CYCLES = cycles_for_us(CLK_FREQ_HZ, INHIBIT_US),
    parameter int START_TIMEOUT  = cycles_for_us(CLK_FREQ_HZ, START_TIMEOUT_US),
    parameter int XFER_TIMEOUT   = cycles_for_us(CLK_FREQ_HZ, XFER_TIMEOUT_US),
    parameter int FILTER_LEN     = DEF_FILTER_LEN
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       error,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int TMAX = max3(INHIBIT_CYCLES, START_TIMEOUT, XFER_TIMEOUT);
    localparam int TW   = $clog2(TMAX + 1);

    ps2_state_e    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    bit_q, bit_d;
    logic [7:0]    data_q, data_d;
    logic          clk_oe_q, clk_oe_d;
    logic          dat_oe_q, dat_oe_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic          nack_q, nack_d;
    logic          clk_prev_q, clk_prev_d;

    logic          clk_filt, dat_filt, clk_fall;
    logic [TW-1:0] timeout_lim;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk      (clk),
        .reset    (reset),
        .pad_in   (ps2_clk_in),
        .filt_out (clk_filt)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
        .clk      (clk),
        .reset    (reset),
        .pad_in   (ps2_dat_in),
        .filt_out (dat_filt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            bit_q      <= '0;
            data_q     <= '0;
            clk_oe_q   <= 1'b0;
            dat_oe_q   <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            nack_q     <= 1'b0;
            clk_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_q      <= bit_d;
            data_q     <= data_d;
            clk_oe_q   <= clk_oe_d;
            dat_oe_q   <= dat_oe_d;
            done_q     <= done_d;
            error_q    <= error_d;
            nack_q     <= nack_d;
            clk_prev_q <= clk_prev_d;
        end
    end

    assign clk_fall = clk_prev_q & ~clk_filt;

    // timer_q counts cycles since the reference point (clock release, then first edge);
    // firing two short lets ERR and DONE land done exactly on the limit.
    assign timeout_lim = (bit_q == 4'd0) ? TW'(START_TIMEOUT - 2) : TW'(XFER_TIMEOUT - 2);

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        bit_d      = bit_q;
        data_d     = data_q;
        clk_oe_d   = clk_oe_q;
        dat_oe_d   = dat_oe_q;
        done_d     = 1'b0;
        error_d    = error_q;
        nack_d     = nack_q;
        clk_prev_d = clk_filt;

        case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    data_d   = tx_data;
                    state_d  = INHIBIT;
                    clk_oe_d = 1'b1;
                    timer_d  = '0;
                    nack_d   = 1'b0;
                    error_d  = 1'b0;
                end
            end
            INHIBIT: begin
                timer_d = timer_q + 1'b1;
                if (timer_q == TW'(INHIBIT_CYCLES - 2)) begin
                    state_d  = START;
                    dat_oe_d = 1'b1;
                end
            end
            START: begin
                state_d  = WAIT_EDGE;
                clk_oe_d = 1'b0;
                bit_d    = '0;
                timer_d  = '0;
            end
            WAIT_EDGE: begin
                timer_d = timer_q + 1'b1;
                if (timer_q == timeout_lim) begin
                    state_d  = ERR;
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                end else if (clk_fall) begin
                    bit_d = bit_q + 1'b1;
                    if (bit_q == 4'd0) begin
                        timer_d = TW'(1);
                    end
                    if (bit_q < 4'd8) begin
                        dat_oe_d = ~data_q[bit_q[2:0]];
                    end else if (bit_q == 4'd8) begin
                        dat_oe_d = ~odd_parity(data_q);
                    end else if (bit_q == 4'd9) begin
                        dat_oe_d = 1'b0;
                    end else begin
                        nack_d  = dat_filt;
                        state_d = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (clk_filt && dat_filt) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    error_d = nack_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            ERR: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                state_d  = DONE;
                done_d   = 1'b1;
                error_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign tx_ready   = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign error      = error_q;
    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-collector device model clocks frames and checks them
// against a frame model built from the byte value.
module tb_ps2_host_tx;

    localparam int IC       = 20;
    localparam int ST       = 400;
    localparam int XT       = 600;
    localparam int FL       = 4;
    localparam int H        = 15;
    localparam int EDGE_LAT = 2 + FL + 1;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, busy, done, error, ps2_clk_oe, ps2_dat_oe;
    logic       dev_clk_pull = 1'b0;
    logic       dev_dat_pull = 1'b0;
    logic       pad_clk, pad_dat;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   t_first = 0;
    int   first_lat = 0;
    logic samp[$];

    assign pad_clk = ~(ps2_clk_oe | dev_clk_pull);
    assign pad_dat = ~(ps2_dat_oe | dev_dat_pull);

    ps2_host_tx #(
        .CLK_FREQ_HZ    (50_000_000),
        .INHIBIT_CYCLES (IC),
        .START_TIMEOUT  (ST),
        .XFER_TIMEOUT   (XT),
        .FILTER_LEN     (FL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .ps2_clk_in (pad_clk),
        .ps2_dat_in (pad_dat),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_n(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Line values a device sees on its rising clock edges: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] frame_of(input logic [7:0] b);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = b[i];
        f[9]  = (($countones(b) % 2) == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic send(input logic [7:0] b);
        int   n;
        logic d_prev, d_last;
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = ~b;
        chk_b("accept_clk_oe", ps2_clk_oe, 1'b1);
        chk_b("accept_ready", tx_ready, 1'b0);
        chk_b("accept_busy", busy, 1'b1);
        n = 0;
        d_prev = 1'b0;
        d_last = 1'b0;
        while (ps2_clk_oe === 1'b1 && n < IC + 10) begin
            n++;
            d_prev = d_last;
            d_last = ps2_dat_oe;
            @(negedge clk);
        end
        chk_n("inhibit_len", n, IC);
        chk_b("start_dat_oe", d_last, 1'b1);
        chk_b("pre_start_dat_oe", d_prev, 1'b0);
    endtask

    // Starts in the first cycle after clock release; samples DAT as each clock pulse rises.
    task automatic dev_run(input int pulses, input bit ack, input bit glitch);
        logic dat_before;
        samp.delete();
        samp.push_back(pad_dat);
        first_lat = 0;
        repeat (H) @(negedge clk);
        for (int i = 0; i < pulses; i++) begin
            dat_before   = ps2_dat_oe;
            dev_clk_pull = 1'b1;
            if (i == 0) t_first = cyc;
            for (int c = 1; c <= H; c++) begin
                @(negedge clk);
                if (i == 0 && first_lat == 0 && ps2_dat_oe !== dat_before) first_lat = c;
            end
            if (i < 10) samp.push_back(pad_dat);
            dev_clk_pull = 1'b0;
            if (i == 9 && ack) dev_dat_pull = 1'b1;
            if (i == 10) dev_dat_pull = 1'b0;
            if (i != pulses - 1) begin
                if (glitch && i == 3) begin
                    repeat (5) @(negedge clk);
                    dev_clk_pull = 1'b1;
                    repeat (3) @(negedge clk);
                    dev_clk_pull = 1'b0;
                    repeat (H - 8) @(negedge clk);
                end else begin
                    repeat (H) @(negedge clk);
                end
            end
        end
    endtask

    task automatic check_frame(input string tag, input logic [7:0] b);
        logic [10:0] f;
        f = frame_of(b);
        chk_n({tag, "_frame_len"}, samp.size(), 11);
        for (int i = 0; i < 11 && i < samp.size(); i++)
            chk_b($sformatf("%s_bit%0d", tag, i), samp[i], f[i]);
    endtask

    task automatic finish_xfer(input string tag, input int limit, input logic exp_err, output int n);
        n = 0;
        while (done !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk_b({tag, "_done"}, done, 1'b1);
        chk_b({tag, "_error"}, error, exp_err);
        chk_b({tag, "_clk_oe"}, ps2_clk_oe, 1'b0);
        chk_b({tag, "_dat_oe"}, ps2_dat_oe, 1'b0);
        chk_b({tag, "_busy_at_done"}, busy, 1'b1);
        @(negedge clk);
        chk_b({tag, "_done_pulse"}, done, 1'b0);
        chk_b({tag, "_ready_after"}, tx_ready, 1'b1);
        chk_b({tag, "_busy_after"}, busy, 1'b0);
    endtask

    task automatic xfer_ok(input string tag, input logic [7:0] b, input bit glitch);
        int n;
        send(b);
        dev_run(11, 1'b1, glitch);
        check_frame(tag, b);
        finish_xfer(tag, 100, 1'b0, n);
    endtask

    initial begin
        int         n;
        logic [7:0] b;

        repeat (3) @(negedge clk);
        chk_b("rst_clk_oe_in_reset", ps2_clk_oe, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk_b("rst_ready", tx_ready, 1'b1);
        chk_b("rst_busy", busy, 1'b0);
        chk_b("rst_done", done, 1'b0);
        chk_b("rst_error", error, 1'b0);
        chk_b("rst_clk_oe", ps2_clk_oe, 1'b0);
        chk_b("rst_dat_oe", ps2_dat_oe, 1'b0);

        xfer_ok("ed", 8'hED, 1'b0);
        chk_n("ed_edge_to_dat_oe", first_lat, EDGE_LAT);

        xfer_ok("zero", 8'h00, 1'b0);
        chk_b("zero_parity", samp[9], 1'b1);
        xfer_ok("f4", 8'hF4, 1'b0);
        chk_b("f4_parity", samp[9], 1'b0);

        for (int r = 0; r < 6; r++) begin
            b = 8'($urandom);
            xfer_ok($sformatf("rnd%0d_%02h", r, b), b, r == 2);
        end
        xfer_ok("glitch", 8'h5A, 1'b1);

        // A second request raised mid-transfer must neither be taken nor disturb the byte in flight.
        send(8'h3C);
        tx_valid = 1'b1;
        tx_data  = 8'hC3;
        dev_run(11, 1'b1, 1'b0);
        chk_b("busy_req_ready", tx_ready, 1'b0);
        tx_valid = 1'b0;
        check_frame("busy_req", 8'h3C);
        finish_xfer("busy_req", 100, 1'b0, n);

        send(8'hF4);
        dev_run(11, 1'b0, 1'b0);
        check_frame("nack", 8'hF4);
        finish_xfer("nack", 100, 1'b1, n);

        send(8'h12);
        finish_xfer("start_to", ST + 20, 1'b1, n);
        chk_n("start_to_cycles", n, ST);

        b = 8'hED;
        send(b);
        dev_run(5, 1'b0, 1'b0);
        chk_b("xfer_to_dat_oe_n4", ps2_dat_oe, ~b[4]);
        finish_xfer("xfer_to", XT + 100, 1'b1, n);
        chk_n("xfer_to_cycles", cyc - 1 - t_first, XT + EDGE_LAT - 1);

        send(b);
        dev_run(4, 1'b0, 1'b0);
        repeat (H) @(negedge clk);
        dev_clk_pull = 1'b1;
        repeat (EDGE_LAT + 1) @(negedge clk);
        chk_b("rst_mid_dat_oe_n4", ps2_dat_oe, ~b[4]);
        #2 reset = 1'b0;
        #1;
        chk_b("rst_mid_clk_oe", ps2_clk_oe, 1'b0);
        chk_b("rst_mid_dat_oe", ps2_dat_oe, 1'b0);
        dev_clk_pull = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_b("rst_mid_ready", tx_ready, 1'b1);
        chk_b("rst_mid_busy", busy, 1'b0);
        repeat (EDGE_LAT + 2) @(negedge clk);
        xfer_ok("post_rst", 8'hF4, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
